// File: rtl/key_debounce_4_pkg.sv
// Shared definitions for the key conditioner and the downstream 4-to-2 encoder.
//   KEY_W       : number of key/request lines (also the encoder d_in width)
//   out_state_e : output handshake FSM states
package enc_pkg;

    localparam int unsigned KEY_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } out_state_e;

endpackage

// File: rtl/key_debounce_4_if.sv
// Valid/ready link carrying a captured key vector to the encoder stage.
//   key_vec   : captured debounced vector (encoder d_in)
//   key_valid : key_vec holds an unconsumed event
//   key_ready : downstream accepts the event this cycle
// master = producer (key_debounce_4), slave = consumer (encoder).
interface key_debounce_4_if;
    import enc_pkg::*;

    logic [KEY_W-1:0] key_vec;
    logic             key_valid;
    logic             key_ready;

    modport master (
        output key_vec,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_vec,
        input  key_valid,
        output key_ready
    );

endinterface

// File: rtl/key_debounce_4_bit.sv
// One-line synchroniser and debouncer.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw_i      : asynchronous raw line
//   st_o       : debounced stable value; follows the synchronised line only after it has
//                differed for DEBOUNCE_CYCLES consecutive cycles
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic st_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            st_q;
    logic            st_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        st_d  = st_q;
        cnt_d = '0;
        if (sync2_q != st_q) begin
            if (cnt_q == CntMax) begin
                st_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            st_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
        end
    end

    assign st_o = st_q;

endmodule

// File: rtl/key_debounce_4.sv
// Key/request line conditioner feeding the 4-to-2 encoder.
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_raw     : asynchronous raw lines, active-high
//   key_overrun : sticky, set when an event arrives while the previous one is unconsumed
//   ovr_clr     : synchronous clear of key_overrun (a simultaneous set wins)
//   out_if      : valid/ready link carrying the captured vector downstream
// Every debounced change to a non-zero vector is one event; multi-line vectors are passed
// unchanged so the encoder can flag them.
module key_debounce_4
    import enc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_W-1:0]   key_raw,
    output logic               key_overrun,
    input  logic               ovr_clr,
    key_debounce_4_if.master   out_if
);

    logic [KEY_W-1:0] st;
    logic [KEY_W-1:0] st_prev_q;
    logic             evt;

    out_state_e       state_q;
    out_state_e       state_d;
    logic [KEY_W-1:0] key_vec_q;
    logic [KEY_W-1:0] key_vec_d;
    logic             ovr_q;
    logic             ovr_d;
    logic             ovr_set;

    for (genvar i = 0; i < KEY_W; i++) begin : g_line
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .raw_i (key_raw[i]),
            .st_o  (st[i])
        );
    end

    // Both registers reset to zero, so reset release can never look like a change.
    assign evt = (st != st_prev_q) && (st != '0);

    always_comb begin
        state_d   = state_q;
        key_vec_d = key_vec_q;
        ovr_set   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (evt) begin
                    key_vec_d = st;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (out_if.key_ready) begin
                    // Acceptance and a new event on the same edge: hand over straight away.
                    if (evt) begin
                        key_vec_d = st;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (evt) begin
                    ovr_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ovr_d = ovr_q;
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_prev_q <= '0;
            state_q   <= IDLE;
            key_vec_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            st_prev_q <= st;
            state_q   <= state_d;
            key_vec_q <= key_vec_d;
            ovr_q     <= ovr_d;
        end
    end

    assign out_if.key_vec   = key_vec_q;
    assign out_if.key_valid = (state_q == HOLD);
    assign key_overrun      = ovr_q;

endmodule

// File: doc/key_debounce_4.md
# key_debounce_4

Input conditioner that sits directly upstream of the 4-to-2 encoder. It synchronises and debounces four raw key/request lines. On each debounced change to a non-zero vector it captures the 4-bit line vector and presents it to the encoder stage with a valid/ready handshake. Multi-line vectors are passed through unchanged so the downstream encoder can flag them as invalid.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive synchronised cycles a line must differ from its stable value before the stable value updates; legal range ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- key_raw  input  4  asynchronous raw lines, active-high.
- key_vec  output  4  captured debounced vector, driven into the encoder's d_in.
- key_valid  output  1  key_vec holds an unconsumed event.
- key_ready  input  1  downstream accepts the event this cycle.
- key_overrun  output  1  sticky flag: an event was dropped.
- ovr_clr  input  1  synchronous clear of key_overrun.

## Operation
- Per line, a 2-FF synchroniser produces s[i].
- Per line, a debounce counter of width $clog2(DEBOUNCE_CYCLES) runs against the stable value st[i]:
  - s[i]==st[i]: counter <= 0.
  - s[i]!=st[i] and counter < DEBOUNCE_CYCLES-1: counter++.
  - s[i]!=st[i] and counter == DEBOUNCE_CYCLES-1: st[i] <= s[i] and counter <= 0.
- Event: in any cycle where st changes (one or more lines, same edge) and the new st != 4'b0000. One event per change, so a later second press produces a new event with a multi-bit vector.
- Release to st == 0 produces no event.
- Output FSM, package enum:
  - IDLE: key_valid=0. On event: key_vec <= new st and go to HOLD.
  - HOLD: key_valid=1 and key_vec is stable.
  - key_ready=1 with no event: go to IDLE. key_vec keeps its last value.
  - key_ready=1 with an event in the same cycle: load the new vector and stay in HOLD. No overrun.
  - key_ready=0 with an event: drop the new event, keep the old key_vec, set key_overrun.
- key_overrun:
  - Set has priority over ovr_clr in the same cycle.
  - Otherwise ovr_clr=1 clears it.
- Reset (asynchronous, at any point including mid-debounce or HOLD): synchronisers, st, counters and key_vec all go to 0. key_valid=0, key_overrun=0, state=IDLE. No event is generated on reset release.

## Timing
- Raw edge latched at clock edge 0 reaches s after edge 1.
- st updates at edge 1+DEBOUNCE_CYCLES.
- key_valid rises after edge 2+DEBOUNCE_CYCLES. Total latency is DEBOUNCE_CYCLES+3 edges.
- Glitches held for fewer than DEBOUNCE_CYCLES synchronised cycles produce no event.
- key_vec and key_valid are registered outputs with no combinational path from key_ready or key_raw.
- Handshake completes on any edge with key_valid & key_ready. key_valid may not drop without it.
- Throughput: at most one event per cycle. Back-to-back acceptance is supported.

## Structure
- Package enc_pkg:
  - KEY_W=4.
  - Output FSM state enum {IDLE, HOLD}.
  - Shared with the encoder for d_in width.
- Sub-module debounce_bit: synchroniser, counter and st for one line, parameterised by DEBOUNCE_CYCLES. Instantiated KEY_W times.
- Top level holds the change/event detect, output FSM and overrun logic.

## Test plan
All cases use DEBOUNCE_CYCLES=4.
1. Reset values: assert rst_n=0 mid-HOLD -> outputs 0 immediately; after release, key_raw=0 -> key_valid stays 0.
2. Single press: key_raw=4'b0100 held, key_ready=1 -> key_valid high for exactly one cycle after 7 edges, with key_vec=4'b0100. Release -> no event.
3. Glitch rejection: key_raw=4'b0001 for 3 cycles, then 0 -> no event, st stays 0.
4. Multi-press: 4'b0010 stable, then 4'b1010 stable -> two events with key_vec=4'b0010 then 4'b1010, the second driving the encoder's invalid output.
5. Backpressure: key_ready=0, event 4'b0001, then event 4'b0011 -> key_vec stays 4'b0001 and key_overrun=1. key_ready=1 -> accepted. ovr_clr pulse -> key_overrun=0.
6. Simultaneous: key_ready=1 on the same edge a new event 4'b1000 arrives while in HOLD -> key_valid stays 1, key_vec=4'b1000, key_overrun stays 0.
